// File: rtl/foc_pkg.sv
// Shared definitions for the FOC regulator blocks: PI schedule states and default widths.
package foc_pkg;

    localparam int PI_N = 10;
    localparam int PI_F = 9;
    localparam int PI_A = PI_N + 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ERR  = 3'd1,
        PROP = 3'd2,
        INTG = 3'd3,
        OUT  = 3'd4
    } pi_state_t;

endpackage

// File: rtl/pi_controller_if.sv
// Sample/result handshake bundle between the PI regulator and its producer/consumer.
import foc_pkg::*;

interface pi_controller_if #(
    parameter int N = PI_N,
    parameter int A = PI_A
) ();

    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] ref_sp;
    logic signed [N-1:0] meas;
    logic signed [N-1:0] kp;
    logic signed [N-1:0] ki;
    logic signed [A-1:0] imax;
    logic signed [A-1:0] imin;
    logic                clr;
    logic signed [N-1:0] y;
    logic                out_valid;

    modport master (
        output in_valid, ref_sp, meas, kp, ki, imax, imin, clr,
        input  in_ready, y, out_valid
    );

    modport slave (
        input  in_valid, ref_sp, meas, kp, ki, imax, imin, clr,
        output in_ready, y, out_valid
    );

endinterface

// File: rtl/saturation.sv
// Signed clamp of an IW-bit value into [i_lo, i_hi] expressed at OW bits (IW must exceed OW).
module saturation #(
    parameter int IW = 15,
    parameter int OW = 14
) (
    input  logic signed [IW-1:0] i_x,
    input  logic signed [OW-1:0] i_lo,
    input  logic signed [OW-1:0] i_hi,
    output logic signed [OW-1:0] o_y
);

    logic signed [IW-1:0] w_lo;
    logic signed [IW-1:0] w_hi;

    assign w_lo = {{(IW-OW){i_lo[OW-1]}}, i_lo};
    assign w_hi = {{(IW-OW){i_hi[OW-1]}}, i_hi};

    always_comb begin
        o_y = i_x[OW-1:0];
        if (i_x > w_hi) begin
            o_y = i_hi;
        end else if (i_x < w_lo) begin
            o_y = i_lo;
        end
    end

endmodule

// File: rtl/pi_controller.sv
// Sequential PI regulator, one shared multiplier over a 5-cycle schedule.
// Define PI_ANTI_WINDUP_EN to bound the integrator by imin/imax instead of its A-bit range.
import foc_pkg::*;

module pi_controller #(
    parameter int N = PI_N,
    parameter int F = PI_F,
    parameter int A = PI_A
) (
    input logic            clk,
    input logic            rst,
    pi_controller_if.slave bus
);

    localparam logic [2:0] S_IDLE = IDLE;
    localparam logic [2:0] S_ERR  = ERR;
    localparam logic [2:0] S_PROP = PROP;
    localparam logic [2:0] S_INTG = INTG;
    localparam logic [2:0] S_OUT  = OUT;

    localparam int PW = 2 * N + 1;
    localparam int SW = PW + A + 1;

    localparam logic signed [N-1:0] Y_LO = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N-1:0] Y_HI = {1'b0, {(N-1){1'b1}}};

    logic [2:0]          r_state;
    logic signed [N-1:0] r_ref;
    logic signed [N-1:0] r_meas;
    logic signed [N-1:0] r_kp;
    logic signed [N-1:0] r_ki;
    logic signed [N:0]   r_e;
    logic signed [A-1:0] r_p;
    logic signed [A-1:0] r_integ;
    logic signed [N-1:0] r_y;
    logic                r_out_valid;

    logic signed [N-1:0]  w_mul_a;
    logic signed [PW-1:0] w_mul_a_ext;
    logic signed [PW-1:0] w_e_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [SW-1:0] w_prod_ext;
    logic signed [SW-1:0] w_shift;
    logic signed [A:0]    w_inc;
    logic signed [A:0]    w_isum;
    logic signed [A:0]    w_osum;
    logic signed [A-1:0]  w_ilo;
    logic signed [A-1:0]  w_ihi;
    logic signed [A-1:0]  w_integ_sat;
    logic signed [N-1:0]  w_y_sat;
    logic                 w_unused_shift;

    // Shared multiplier: kp during PROP, ki otherwise (only consumed in INTG)
    assign w_mul_a     = (r_state == S_PROP) ? r_kp : r_ki;
    assign w_mul_a_ext = {{(PW-N){w_mul_a[N-1]}}, w_mul_a};
    assign w_e_ext     = {{(PW-N-1){r_e[N]}}, r_e};
    assign w_prod      = w_mul_a_ext * w_e_ext;
    assign w_prod_ext  = {{(A+1){w_prod[PW-1]}}, w_prod};
    assign w_shift     = w_prod_ext >>> F;
    assign w_inc       = w_shift[A:0];

    assign w_isum = {r_integ[A-1], r_integ} + w_inc;
    assign w_osum = {r_p[A-1], r_p} + {r_integ[A-1], r_integ};

    assign w_unused_shift = ^w_shift[SW-1:A+1];

`ifdef PI_ANTI_WINDUP_EN
    assign w_ilo = bus.imin;
    assign w_ihi = bus.imax;
`else
    logic w_unused_lim;
    assign w_ilo        = {1'b1, {(A-1){1'b0}}};
    assign w_ihi        = {1'b0, {(A-1){1'b1}}};
    assign w_unused_lim = ^{bus.imin, bus.imax};
`endif

    saturation #(.IW(A + 1), .OW(A)) u_int_sat (
        .i_x  (w_isum),
        .i_lo (w_ilo),
        .i_hi (w_ihi),
        .o_y  (w_integ_sat)
    );

    saturation #(.IW(A + 1), .OW(N)) u_out_sat (
        .i_x  (w_osum),
        .i_lo (Y_LO),
        .i_hi (Y_HI),
        .o_y  (w_y_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ref       <= '0;
            r_meas      <= '0;
            r_kp        <= '0;
            r_ki        <= '0;
            r_e         <= '0;
            r_p         <= '0;
            r_integ     <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_ref   <= bus.ref_sp;
                        r_meas  <= bus.meas;
                        r_kp    <= bus.kp;
                        r_ki    <= bus.ki;
                        r_state <= S_ERR;
                    end
                end
                S_ERR: begin
                    r_e     <= {r_ref[N-1], r_ref} - {r_meas[N-1], r_meas};
                    r_state <= S_PROP;
                end
                S_PROP: begin
                    r_p     <= w_shift[A-1:0];
                    r_state <= S_INTG;
                end
                S_INTG: begin
                    r_integ <= w_integ_sat;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    r_y         <= w_y_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // clr wins over the INTG update so that sample's integral contribution is dropped
            if (bus.clr) begin
                r_integ <= '0;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.y         = r_y;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_pi_controller.sv
// Scoreboard bench for pi_controller; expectations come from a behavioural PI model.
import foc_pkg::*;

module tb_pi_controller;

    localparam int N = PI_N;
    localparam int A = PI_A;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pi_controller_if #(.N(N), .A(A)) bus ();

    pi_controller #(.N(N), .F(PI_F), .A(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    longint m_integ = 0;
    longint m_imin = -8192;
    longint m_imax = 8191;
    logic signed [N-1:0] exp_q[$];

    // Reference PI step: floor-shifted products, clamped integrator, clamped output
    function automatic logic signed [N-1:0] model(input int r, input int m, input int p,
                                                  input int i, input bit clr_intg);
        longint e, pp, t, lo, hi, s;
        e  = longint'(r) - longint'(m);
        pp = (longint'(p) * e) >>> PI_F;
        t  = m_integ + ((longint'(i) * e) >>> PI_F);
`ifdef PI_ANTI_WINDUP_EN
        lo = m_imin;
        hi = m_imax;
`else
        lo = -8192;
        hi = 8191;
`endif
        if (t > hi) t = hi;
        if (t < lo) t = lo;
        m_integ = clr_intg ? 0 : t;
        s = pp + m_integ;
        if (s > 511) s = 511;
        if (s < -512) s = -512;
        return s[N-1:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m_integ = 0;
        exp_q.delete();
    endtask

    task automatic set_limits(input int lo, input int hi);
        bus.imin = A'(lo);
        bus.imax = A'(hi);
        m_imin   = lo;
        m_imax   = hi;
    endtask

    task automatic run_sample(input int r, input int m, input int p, input int i,
                              input int clr_edge, input bit busy, input int rst_edge,
                              output int nv, output int lat, output logic signed [N-1:0] ys,
                              output logic signed [N-1:0] yend, output bit rdy_ok);
        @(negedge clk);
        bus.ref_sp   = N'(r);
        bus.meas     = N'(m);
        bus.kp       = N'(p);
        bus.ki       = N'(i);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.ref_sp   = N'($urandom);
        bus.meas     = N'($urandom);
        bus.kp       = N'($urandom);
        bus.ki       = N'($urandom);
        nv = 0;
        lat = -1;
        ys = '0;
        rdy_ok = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            bus.in_valid = busy && (k <= 3);
            bus.clr      = (k == clr_edge);
            @(posedge clk);
            #1;
            if (k == rst_edge) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            if (k <= 3 && bus.in_ready !== 1'b0) rdy_ok = 1'b0;
            if (k == 4 && bus.in_ready !== 1'b1) rdy_ok = 1'b0;
            if (bus.out_valid === 1'b1) begin
                nv++;
                if (lat < 0) begin
                    lat = k;
                    ys  = bus.y;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
        yend         = bus.y;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.clr = 1'b0;
        bus.ref_sp = '0;
        bus.meas = '0;
        bus.kp = '0;
        bus.ki = '0;
        set_limits(-8192, 8191);
        #1;
        n_cmp++;
        if (bus.y !== '0) begin
            n_bad++; $display("FAIL reset_y: got %0d expected 0", bus.y);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int nv, lat;
        logic signed [N-1:0] ys, yend, e;
        bit rdy;
        int want[2] = '{192, 256};
        for (int s = 0; s < 2; s++) begin
            exp_q.push_back(model(256, 0, 256, 128, 1'b0));
            run_sample(256, 0, 256, 128, -1, 1'b0, -1, nv, lat, ys, yend, rdy);
            e = exp_q.pop_front();
            n_cmp++;
            if (ys !== e || ys !== N'(want[s])) begin
                n_bad++;
                $display("FAIL basic_y[%0d]: got %0d expected %0d (model %0d)", s, ys, want[s], e);
            end
            n_cmp++;
            if (lat != 4 || nv != 1) begin
                n_bad++;
                $display("FAIL basic_timing[%0d]: latency %0d pulses %0d expected 4/1", s, lat, nv);
            end
            n_cmp++;
            if (yend !== ys || rdy !== 1'b1) begin
                n_bad++;
                $display("FAIL basic_hold[%0d]: y %0d ready_ok %b expected %0d/1", s, yend, rdy, ys);
            end
        end
    endtask

    task automatic test_overflow();
        int nv, lat;
        logic signed [N-1:0] ys, yend, e;
        bit rdy;
        int rr[2] = '{511, -512};
        int mm[2] = '{-512, 511};
        int want[2] = '{511, -512};
        do_reset();
        for (int s = 0; s < 2; s++) begin
            exp_q.push_back(model(rr[s], mm[s], 511, 0, 1'b0));
            run_sample(rr[s], mm[s], 511, 0, -1, 1'b0, -1, nv, lat, ys, yend, rdy);
            e = exp_q.pop_front();
            n_cmp++;
            if (ys !== e || ys !== N'(want[s]) || lat != 4) begin
                n_bad++;
                $display("FAIL overflow_y[%0d]: got %0d lat %0d expected %0d (model %0d)",
                         s, ys, lat, want[s], e);
            end
        end
    endtask

    task automatic test_windup();
        int nv, lat;
        logic signed [N-1:0] ys, yend, e;
        bit rdy;
        int want[3];
`ifdef PI_ANTI_WINDUP_EN
        want = '{64, 100, 100};
        set_limits(-100, 100);
`else
        want = '{64, 128, 192};
        set_limits(-100, 100);
`endif
        do_reset();
        for (int s = 0; s < 3; s++) begin
            exp_q.push_back(model(256, 0, 0, 128, 1'b0));
            run_sample(256, 0, 0, 128, -1, 1'b0, -1, nv, lat, ys, yend, rdy);
            e = exp_q.pop_front();
            n_cmp++;
            if (ys !== e || ys !== N'(want[s])) begin
                n_bad++;
                $display("FAIL windup_y[%0d]: got %0d expected %0d (model %0d)", s, ys, want[s], e);
            end
        end
        // Drive the integrator into its A-bit rail and back down through the linear range
        set_limits(-8192, 8191);
        do_reset();
        for (int s = 0; s < 20; s++) begin
            int r = (s < 10) ? 511 : -512;
            int m = (s < 10) ? -512 : 511;
            exp_q.push_back(model(r, m, 0, 511, 1'b0));
            run_sample(r, m, 0, 511, -1, 1'b0, -1, nv, lat, ys, yend, rdy);
            e = exp_q.pop_front();
            n_cmp++;
            if (ys !== e) begin
                n_bad++;
                $display("FAIL integ_rail[%0d]: got %0d expected %0d", s, ys, e);
            end
        end
    endtask

    task automatic test_busy_clear();
        int nv, lat;
        logic signed [N-1:0] ys, yend, e;
        bit rdy;
        do_reset();
        exp_q.push_back(model(256, 0, 256, 128, 1'b0));
        run_sample(256, 0, 256, 128, -1, 1'b1, -1, nv, lat, ys, yend, rdy);
        e = exp_q.pop_front();
        n_cmp++;
        if (nv != 1 || ys !== e || lat != 4) begin
            n_bad++;
            $display("FAIL busy_ignore: pulses %0d y %0d lat %0d expected 1/%0d/4", nv, ys, lat, e);
        end
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_bad++; $display("FAIL busy_ready: got %b expected 1", rdy);
        end
        exp_q.push_back(model(256, 0, 256, 128, 1'b1));
        run_sample(256, 0, 256, 128, 3, 1'b0, -1, nv, lat, ys, yend, rdy);
        e = exp_q.pop_front();
        n_cmp++;
        if (ys !== e || ys !== 10'sd128) begin
            n_bad++; $display("FAIL clear_y: got %0d expected 128 (model %0d)", ys, e);
        end
        exp_q.push_back(model(0, 0, 0, 0, 1'b0));
        run_sample(0, 0, 0, 0, -1, 1'b0, -1, nv, lat, ys, yend, rdy);
        e = exp_q.pop_front();
        n_cmp++;
        if (ys !== e || ys !== '0) begin
            n_bad++; $display("FAIL clear_integ: got %0d expected 0 (model %0d)", ys, e);
        end
    endtask

    task automatic test_reset_midop();
        int nv, lat;
        logic signed [N-1:0] ys, yend, e;
        bit rdy;
        do_reset();
        exp_q.push_back(model(256, 0, 256, 128, 1'b0));
        run_sample(256, 0, 256, 128, -1, 1'b0, -1, nv, lat, ys, yend, rdy);
        e = exp_q.pop_front();
        n_cmp++;
        if (ys !== e) begin
            n_bad++; $display("FAIL midop_pre: got %0d expected %0d", ys, e);
        end
        run_sample(256, 0, 256, 128, -1, 1'b0, 2, nv, lat, ys, yend, rdy);
        m_integ = 0;
        n_cmp++;
        if (nv != 0 || yend !== '0) begin
            n_bad++; $display("FAIL midop_drop: pulses %0d y %0d expected 0/0", nv, yend);
        end
        exp_q.push_back(model(256, 0, 256, 128, 1'b0));
        run_sample(256, 0, 256, 128, -1, 1'b0, -1, nv, lat, ys, yend, rdy);
        e = exp_q.pop_front();
        n_cmp++;
        if (ys !== e || ys !== 10'sd192 || lat != 4) begin
            n_bad++; $display("FAIL midop_after: got %0d lat %0d expected 192/4", ys, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_windup();
        test_busy_clear();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
